// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the pipelined adder/subtractor.
//   seg_width()   - carry-segment width for a WIDTH/STAGES split
//   smax()/smin() - signed max/min patterns for a given width (LSB-aligned
//                   in a MAX_W-bit word; callers size-cast to their width)
//   mode_e        - encoding of the add/sub select input
package adder_pkg;

    // Widest operand the saturation helpers can describe.
    localparam int MAX_W = 1024;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    // 0x7FF..F for a w-bit signed value.
    function automatic logic [MAX_W-1:0] smax(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w + 1);
    endfunction

    // 0x800..0 for a w-bit signed value.
    function automatic logic [MAX_W-1:0] smin(input int w);
        return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

endpackage

// File: rtl/rca_seg.sv
// rca_seg: combinational W-bit ripple-carry adder segment.
// Ports:
//   a, b : W-bit addends
//   ci   : carry in
//   s    : W-bit sum
//   co   : carry out of the segment MSB
// Each loop iteration is one full-adder bit cell; the carry is walked
// through a local variable so the chain stays a single combinational block.
module rca_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    always_comb begin
        logic c;
        s = '0;
        c = ci;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined two's-complement adder/subtractor.
// A WIDTH-bit add is cut into STAGES carry segments of SEG = WIDTH/STAGES
// bits; stage k adds segment k and registers its carry for stage k+1.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin, sub)
//   sub                  : 0 -> a+b+cin, 1 -> a-b-cin (cin acts as borrow)
//   out_valid / out_ready: result handshake (sum, cout, ovf)
//   cout                 : raw MSB carry; for subtract, borrow = !cout
//   ovf                  : signed overflow of the (unsaturated) result
// Optional feature: define PIPE_ADDER_SAT_EN to clamp sum to signed max/min
// on overflow (ovf/cout still report the unsaturated condition).
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic             en;
    logic [STAGES:1]  vld_pipe;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Per-stage registers. a_q/b_q are the skewed operand copies that carry
    // the not-yet-added upper segments forward; s_q accumulates finished
    // lower segments. s_q[LAST] is the output sum register.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             ovf_q;

    // Stage inputs and next-state values.
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic             c_in  [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic [SEG-1:0]   s_seg [STAGES];
    logic             c_seg [STAGES];
    logic [WIDTH-1:0] fin_sum;
    logic             ovf_nxt;

    // One enable for the whole pipe: a stalled output freezes every stage,
    // bubbles included.
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

    // Subtract as a + ~b + ~cin: the inverted borrow becomes the carry-in.
    assign b_eff = (sub == MODE_SUB) ? ~b : b;
    assign c_eff = (sub == MODE_SUB) ? ~cin : cin;

    // Stage 0 takes the prepared operands; later stages take the previous
    // stage's registers.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            a_in[k] = '0;
            b_in[k] = '0;
            s_in[k] = '0;
            c_in[k] = 1'b0;
        end
        a_in[0] = a;
        b_in[0] = b_eff;
        c_in[0] = c_eff;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        rca_seg #(.W(SEG)) u_rca (
            .a  (a_in[k][k*SEG +: SEG]),
            .b  (b_in[k][k*SEG +: SEG]),
            .ci (c_in[k]),
            .s  (s_seg[k]),
            .co (c_seg[k])
        );
    end

    // Drop each stage's segment result into its slot of the partial sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nxt[k]               = s_in[k];
            s_nxt[k][k*SEG +: SEG] = s_seg[k];
        end
    end

    // Overflow uses the operand MSBs from the skewed copies that reach the
    // final stage alongside the top segment.
    always_comb begin
        ovf_nxt = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                  (s_nxt[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
        fin_sum = s_nxt[LAST];
`ifdef PIPE_ADDER_SAT_EN
        // Both operands share a sign on overflow, so a's MSB picks the rail.
        if (ovf_nxt) begin
            fin_sum = a_in[LAST][WIDTH-1] ? WIDTH'(smin(WIDTH)) : WIDTH'(smax(WIDTH));
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            ovf_q    <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (en) begin
            vld_pipe[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= (k == LAST) ? fin_sum : s_nxt[k];
                c_q[k] <= c_seg[k];
            end
            ovf_q <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: randomized self-checking bench for pipe_adder.
// Expected results come from signed/unsigned integer arithmetic on the
// operands, queued in acceptance order and compared on each output handshake.
`timescale 1ns/1ps
module tb_pipe_adder;

    localparam int     WIDTH  = 32;
    localparam int     STAGES = 4;
    localparam longint SMAX   = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
    localparam longint SMIN   = -(64'sd1 <<< (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc_cyc;
    } exp_t;

    exp_t             exp_q[$];
    int               n_chk = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               n_out = 0;
    bit               lat_mode = 1'b0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;
    logic             prev_ovf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer result, then wrap/saturate and derive flags.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic sb);
        exp_t            e;
        longint          sx, sy, c, r;
        longint unsigned ux, uy, uc;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        c  = ci ? 64'sd1 : 64'sd0;
        ux = x;
        uy = y;
        uc = ci ? 64'd1 : 64'd0;
        if (sb) begin
            r      = sx - sy - c;
            e.cout = (ux >= uy + uc);            // no borrow
        end else begin
            r      = sx + sy + c;
            e.cout = ((ux + uy + uc) >> WIDTH) != 0;
        end
        e.ovf     = (r > SMAX) || (r < SMIN);
        e.sum     = r[WIDTH-1:0];
`ifdef PIPE_ADDER_SAT_EN
        if (e.ovf) e.sum = (r > 0) ? WIDTH'(SMAX) : WIDTH'(SMIN);
`endif
        e.acc_cyc = 0;
        return e;
    endfunction

    // One clock: called at a negedge with inputs already driven.
    task automatic step(output bit acc);
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, prev_sum);
            chk("hold_cout", cout, prev_cout);
            chk("hold_ovf", ovf, prev_ovf);
        end
        if (acc) begin
            e = model(a, b, cin, sub);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", sum, e.sum);
                chk("cout", cout, e.cout);
                chk("ovf", ovf, e.ovf);
                if (lat_mode) chk("latency", cyc - e.acc_cyc, STAGES);
                n_out++;
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum;
        prev_cout  = cout;
        prev_ovf   = ovf;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic sb);
        bit acc;
        int guard;
        a = x; b = y; cin = ci; sub = sb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        do begin
            step(acc);
            guard++;
        end while (!acc && guard < 20);
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", in_ready, 1);
    endtask

    task automatic drain();
        bit acc;
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 50) begin
            step(acc);
            guard++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic rand_ops();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sent;
        int out_base;
        bit tgl;
        int guard;

        // Reset held while the source is already presenting data.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = 32'h1234_5678; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);

        // Directed corner cases, one at a time, latency checked.
        lat_mode = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); drain();  // full ripple
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); drain();  // positive ovf
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0); drain();  // negative ovf
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1); drain();  // borrow
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1); drain();  // borrow-in
        send(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1); drain();  // 0 - min
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0); drain();  // max carry

        // Back-to-back random stream with full-throughput latency check.
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            in_valid = 1'b1;
            step(acc);
        end
        in_valid = 1'b0;
        drain();

        // Eight back-to-back transactions against alternating backpressure.
        lat_mode = 1'b0;
        out_base = n_out;
        sent = 0; tgl = 1'b1; guard = 0;
        rand_ops();
        in_valid = 1'b1;
        while ((sent < 8 || exp_q.size() != 0) && guard < 200) begin
            out_ready = tgl;
            tgl = !tgl;
            step(acc);
            if (acc) begin
                sent++;
                if (sent < 8) rand_ops();
                else in_valid = 1'b0;
            end
            guard++;
        end
        in_valid = 1'b0;
        chk("bp_count", n_out - out_base, 8);

        // Random valid and ready.
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || acc) begin
                rand_ops();
                in_valid = 1'($urandom_range(0, 3) != 0);
            end
            out_ready = 1'($urandom_range(0, 2) != 0);
            step(acc);
        end
        in_valid = 1'b0;
        drain();

        // Reset mid-stream: one result stalled at the output, three behind it.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            step(acc);
        end
        in_valid = 1'b0;
        step(acc);
        chk("pre_rst_valid", out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sum", sum, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        prev_stall = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(acc);
            chk("post_rst_idle", out_valid, 0);
        end
        lat_mode = 1'b1;
        send(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0); drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
